// File: rtl/bcast_unit.sv
// Replicates one 82-bit payload to every port set in a destination mask, lowest index first.
// Optional feature: define BCAST_STATS_EN to add the 16-bit copy_count handshake counter port.
module bcast_unit #(
  parameter int NPORTS = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [81:0]       in_packet,
  input  logic [NPORTS-1:0] in_mask,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [84:0]       out_packet,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
`ifdef BCAST_STATS_EN
  ,
  output logic [15:0]       copy_count
`endif
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic [NPORTS-1:0] MASK_ONE  = NPORTS'(1);
  localparam logic [NPORTS-1:0] MASK_ZERO = {NPORTS{1'b0}};

  state_t            state_r;
  logic [NPORTS-1:0] mask_r;
  logic [84:0]       out_packet_r;
  logic              out_valid_r;
  logic              busy_r;
  logic              idle_r;
  logic [NPORTS-1:0] next_mask_s;

  function automatic logic [2:0] lowest_idx(input logic [NPORTS-1:0] m);
    lowest_idx = 3'd0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if (m[i]) begin
        lowest_idx = 3'(i);
      end
    end
  endfunction

  // Clearing the lowest set bit yields the mask that remains after the current copy.
  assign next_mask_s = mask_r & (mask_r - MASK_ONE);

  // Gating with rst keeps in_ready low during reset yet high on the very first edge after release.
  assign in_ready   = idle_r & rst;
  assign out_packet = out_packet_r;
  assign out_valid  = out_valid_r;
  assign busy       = busy_r;

  // Replication FSM; all outputs are registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      mask_r       <= MASK_ZERO;
      out_packet_r <= 85'd0;
      out_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      idle_r       <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          // A zero mask still completes the handshake but is simply dropped.
          if (in_valid && (in_mask != MASK_ZERO)) begin
            mask_r       <= in_mask;
            out_packet_r <= {lowest_idx(in_mask), in_packet};
            out_valid_r  <= 1'b1;
            busy_r       <= 1'b1;
            idle_r       <= 1'b0;
            state_r      <= EMIT;
          end else begin
            state_r <= IDLE;
          end
        end
        EMIT: begin
          if (out_ready) begin
            mask_r <= next_mask_s;
            if (next_mask_s == MASK_ZERO) begin
              out_valid_r <= 1'b0;
              busy_r      <= 1'b0;
              idle_r      <= 1'b1;
              state_r     <= IDLE;
            end else begin
              out_packet_r[84:82] <= lowest_idx(next_mask_s);
            end
          end else begin
            state_r <= EMIT;
          end
        end
        default: begin
          state_r     <= IDLE;
          mask_r      <= MASK_ZERO;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          idle_r      <= 1'b1;
        end
      endcase
    end
  end

`ifdef BCAST_STATS_EN
  logic [15:0] copy_count_r;

  assign copy_count = copy_count_r;

  // Counts every completed output handshake; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      copy_count_r <= 16'd0;
    end else if (out_valid_r && out_ready) begin
      copy_count_r <= copy_count_r + 16'd1;
    end else begin
      copy_count_r <= copy_count_r;
    end
  end
`endif

endmodule

// File: tb/tb_bcast_unit.sv
// Self-checking bench for bcast_unit: directed scenarios plus randomized packets against a queue-based model.
module tb_bcast_unit;

  localparam int NP = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [81:0]   in_packet = 82'd0;
  logic [NP-1:0] in_mask = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [84:0]   out_packet;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy;
  int            checks = 0;
  int            errors = 0;
  int            model_count = 0;
`ifdef BCAST_STATS_EN
  logic [15:0]   copy_count;
`endif

  bcast_unit #(.NPORTS(NP)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_packet (in_packet),
    .in_mask   (in_mask),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_packet(out_packet),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
`ifdef BCAST_STATS_EN
    ,
    .copy_count(copy_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [84:0] obs, input logic [84:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_in_ready"}, 85'(in_ready), 85'd1);
    chk({tag, "_out_valid"}, 85'(out_valid), 85'd0);
    chk({tag, "_busy"}, 85'(busy), 85'd0);
  endtask

  // mode 0: out_ready always 1; 1: random; 2: stalled for the first 4 cycles
  task automatic send(input logic [81:0] pay, input logic [NP-1:0] m, input int mode);
    int   q[$];
    int   cyc;
    logic hs;
    for (int i = 0; i < NP; i++) begin
      if (m[i]) q.push_back(i);
    end
    chk("pre_in_ready", 85'(in_ready), 85'd1);
    in_valid  = 1'b1;
    in_packet = pay;
    in_mask   = m;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (q.size() > 0 && cyc < 200) begin
      chk("emit_valid", 85'(out_valid), 85'd1);
      chk("emit_busy", 85'(busy), 85'd1);
      chk("emit_in_ready", 85'(in_ready), 85'd0);
      chk("emit_packet", out_packet, {3'(q[0]), pay});
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        2:       out_ready = (cyc >= 4);
        default: out_ready = 1'b1;
      endcase
      // Junk inputs while busy must never be captured.
      in_valid  = 1'($urandom_range(0, 1));
      in_packet = 82'({$urandom, $urandom, $urandom});
      in_mask   = NP'($urandom);
      hs = out_ready;
      @(negedge clk);
      if (hs) begin
        void'(q.pop_front());
        model_count++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    chk("copies_left", 85'(q.size()), 85'd0);
    idle_checks("after_packet");
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 85'(in_ready), 85'd0);
    chk("rst_out_valid", 85'(out_valid), 85'd0);
    chk("rst_busy", 85'(busy), 85'd0);
    chk("rst_out_packet", out_packet, 85'd0);
    rst = 1'b1;
    #1;
    chk("rel_in_ready", 85'(in_ready), 85'd1);
    @(negedge clk);

    send(82'h1234, 6'b000001, 0);
    send(82'h3_DEAD_BEEF_0123_4567, 6'b101010, 0);
    send(82'h2_AAAA_5555_AAAA_5555, 6'b000110, 2);

    // Zero mask: accepted and dropped.
    in_valid = 1'b1;
    in_mask  = 6'b000000;
    in_packet = 82'h77;
    @(negedge clk);
    in_valid = 1'b0;
    idle_checks("zero_mask");
    @(negedge clk);
    idle_checks("zero_mask_next");

    // Reset in the middle of a six-copy packet.
    in_valid  = 1'b1;
    in_mask   = 6'b111111;
    in_packet = 82'h1_0000_CAFE;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_tag0", out_packet, {3'd0, 82'h1_0000_CAFE});
    @(negedge clk);
    chk("mid_tag1", out_packet, {3'd1, 82'h1_0000_CAFE});
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 85'(out_valid), 85'd0);
    chk("mid_rst_busy", 85'(busy), 85'd0);
    chk("mid_rst_in_ready", 85'(in_ready), 85'd0);
    chk("mid_rst_packet", out_packet, 85'd0);
    model_count = 0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_rst_in_ready", 85'(in_ready), 85'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_checks("post_rst_quiet");
    end

`ifdef BCAST_STATS_EN
    send(82'h11, 6'b111111, 0);
    send(82'h22, 6'b000011, 0);
    chk("stats_eight", 85'(copy_count), 85'd8);
`endif

    for (int n = 0; n < 40; n++) begin
      send(82'({$urandom, $urandom, $urandom}), NP'($urandom), n % 2);
    end
`ifdef BCAST_STATS_EN
    chk("stats_random", 85'(copy_count), 85'(16'(model_count)));
    while (model_count < 65536 + 8) begin
      send(82'(model_count), 6'b111111, 0);
    end
    chk("stats_wrap", 85'(copy_count), 85'(16'(model_count)));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcast_unit.md
BCAST_UNIT -- requirements
Module: bcast_unit

Interface
REQ-001 Parameter: NPORTS, default 6, number of output directions to replicate to (legal 1..8).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_packet  input  82  payload to replicate.
REQ-005 Port: in_mask  input  NPORTS  destination bitmask; bit i set means one copy for port i.
REQ-006 Port: in_valid  input  1  in_packet/in_mask valid.
REQ-007 Port: in_ready  output  1  block can accept an input this cycle.
REQ-008 Port: out_packet  output  85  {port_idx[2:0], payload[81:0]}.
REQ-009 Port: out_valid  output  1  out_packet valid.
REQ-010 Port: out_ready  input  1  downstream accepts out_packet this cycle.
REQ-011 Port: busy  output  1  high while copies remain to be emitted.

Function
REQ-012 Two states SHALL exist: IDLE and EMIT.
REQ-013 IDLE: in_ready=1, out_valid=0, busy=0.
REQ-014 IDLE with in_valid=1 and in_mask!=0: capture in_packet and in_mask on the clock edge, then enter EMIT.
REQ-015 IDLE with in_valid=1 and in_mask==0: accept the input (handshake completes), drop it, produce no output, remain in IDLE.
REQ-016 EMIT: in_ready=0, busy=1, out_valid=1.
REQ-017 EMIT: out_packet[84:82] = index of the lowest set bit of the remaining mask; out_packet[81:0] = captured payload, unmodified.
REQ-018 EMIT with out_ready=1: clear that lowest set bit; if the remaining mask becomes zero, return to IDLE, else stay in EMIT and present the next index the following cycle.
REQ-019 EMIT with out_ready=0: out_packet and out_valid held stable; no state change.
REQ-020 Latency: the first copy is valid the cycle after input acceptance. With out_ready held at 1, k copies occupy k consecutive cycles.
REQ-021 Copies SHALL be emitted in ascending port index order.
REQ-022 No input is accepted in the cycle the last copy handshakes; in_ready rises the next cycle (one bubble per packet).
REQ-023 in_mask bits at or above NPORTS do not exist; tag values >= NPORTS SHALL never be emitted.
REQ-024 in_valid may drop without being accepted; the block SHALL NOT capture data unless in_valid and in_ready are both 1 on the edge.

Reset
REQ-025 While rst=0: state=IDLE, out_valid=0, out_packet=0, remaining mask=0, busy=0, in_ready=0.
REQ-026 Reset asserted mid-EMIT SHALL immediately discard all remaining copies; no partial copy is emitted after rst deasserts.
REQ-027 The first edge after rst returns to 1 sees in_ready=1.

Configuration
REQ-028 Macro BCAST_STATS_EN: when defined, add output port copy_count (16 bits), which increments by 1 on every out_valid&&out_ready handshake, wraps from 0xFFFF to 0, resets to 0 while rst=0, and does not count dropped zero-mask inputs.
REQ-029 Without BCAST_STATS_EN, the copy_count port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-030 in_mask=6'b000001, payload=0x1234, out_ready=1 -> exactly one out_packet={3'd0,0x1234}, the cycle after acceptance; in_ready=1 the cycle after that handshake.
REQ-031 in_mask=6'b101010, out_ready=1 -> tags 1, 3, 5 on three consecutive cycles with identical payloads; in_ready=0 throughout and 1 on the following cycle.
REQ-032 in_mask=6'b000110, out_ready=0 for 4 cycles then 1 -> tag 1 held stable for 5 cycles, then tag 2 for 1 cycle, then IDLE.
REQ-033 in_mask=0, in_valid=1 -> handshake completes, out_valid stays 0, in_ready stays 1.
REQ-034 in_mask=6'b111111; assert rst=0 after 2 copies -> out_valid=0 at once; after rst deasserts, no further copies, in_ready=1.
REQ-035 With BCAST_STATS_EN: masks 6'b111111 then 6'b000011 -> copy_count=8; preload via 65536 handshakes -> wraps to 0.
